// File: rtl/rv0_dmem_pkg.sv
// Shared AHB-lite encodings and address-check helper for the rv0 data-memory completer.
package rv0_dmem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Sizes above a doubleword are rejected by the size check, so three LSBs suffice.
  function automatic logic addr_misaligned(input logic [2:0] lsb, input logic [2:0] hsize);
    case (hsize)
      3'd0:    return 1'b0;
      3'd1:    return lsb[0];
      3'd2:    return |lsb[1:0];
      default: return |lsb;
    endcase
  endfunction

endpackage

// File: rtl/ahb_if.sv
// AHB-lite single-completer bus between the load/store unit and the data memory.
interface ahb_if #(
  parameter int unsigned XLEN = 32
);
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic              hwrite;
  logic [XLEN-1:0]   hwdata;
  logic [XLEN/8-1:0] hwstrb;
  logic [XLEN-1:0]   hrdata;
  logic              hreadyout;
  logic              hresp;

  modport completer (
    input  hsel, haddr, htrans, hsize, hburst, hwrite, hwdata, hwstrb,
    output hrdata, hreadyout, hresp
  );

  modport requester (
    output hsel, haddr, htrans, hsize, hburst, hwrite, hwdata, hwstrb,
    input  hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/rv0_dmem_ram.sv
// Single-port synchronous RAM with per-byte write enables; read-first, contents not reset.
module rv0_dmem_ram #(
  parameter int unsigned Depth = 16384,
  parameter int unsigned Width = 32,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned NumBytes = Width / 8
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic [NumBytes-1:0] we_i,
  input  logic [AddrW-1:0]    addr_i,
  input  logic [Width-1:0]    wdata_i,
  output logic [Width-1:0]    rdata_o
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_o <= mem[addr_i];
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (we_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/rv0_dmem.sv
// AHB-lite data-memory completer: wait-state insertion, two-cycle ERROR responses and
// write-to-read forwarding for a read issued in the data phase of a same-word write.
module rv0_dmem
  import rv0_dmem_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_SIZE    = 65536,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  ahb_if.completer dmem_if
);

  localparam int unsigned NumBytes = XLEN / 8;
  localparam int unsigned ByteW    = $clog2(NumBytes);
  localparam int unsigned AddrW    = $clog2(MEM_SIZE);
  localparam int unsigned IdxW     = AddrW - ByteW;
  localparam int unsigned Depth    = MEM_SIZE / NumBytes;
  localparam int unsigned CntW     = 3;
  localparam logic [2:0]  MaxSize  = 3'(ByteW);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                write_q, write_d;
  logic                fwd_q, fwd_d;
  logic [XLEN-1:0]     fwd_data_q, fwd_data_d;
  logic [NumBytes-1:0] fwd_strb_q, fwd_strb_d;
  logic [XLEN-1:0]     hold_q, hold_d;

  logic                ready, accept, xfer_err, wr_data, rd_data, port_busy, fast_rd;
  logic [IdxW-1:0]     req_idx;
  logic [XLEN-1:0]     rd_word, ram_rdata;
  logic                ram_en;
  logic [NumBytes-1:0] ram_we;
  logic [IdxW-1:0]     ram_addr;
  logic                unused_hburst;

  assign unused_hburst = ^dmem_if.hburst;

  assign ready    = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign accept   = dmem_if.hsel && ready &&
                    (dmem_if.htrans == HTRANS_NONSEQ || dmem_if.htrans == HTRANS_SEQ);
  assign req_idx  = dmem_if.haddr[AddrW-1:ByteW];
  assign xfer_err = (dmem_if.haddr >= 32'(MEM_SIZE)) || (dmem_if.hsize > MaxSize) ||
                    addr_misaligned(dmem_if.haddr[2:0], dmem_if.hsize);
  assign wr_data  = (state_q == S_DATA) && write_q;
  assign rd_data  = (state_q == S_DATA) && !write_q;
  // The single RAM port is taken by the closing write; a read to another word must wait.
  assign port_busy = wr_data && (req_idx != idx_q);
  assign fast_rd   = accept && !xfer_err && !dmem_if.hwrite && (WAIT_STATES == 0) && !port_busy;

  always_comb begin
    rd_word = ram_rdata;
    if (fwd_q) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (fwd_strb_q[i]) rd_word[8*i +: 8] = fwd_data_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    fwd_strb_d = fwd_strb_q;
    hold_d     = hold_q;
    if (rd_data) hold_d = rd_word;

    case (state_q)
      S_WAIT: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      idx_d   = req_idx;
      write_d = dmem_if.hwrite;
      fwd_d   = 1'b0;
      if (xfer_err) begin
        state_d = S_ERR1;
        hold_d  = '0;
      end else if (WAIT_STATES != 0) begin
        state_d = S_WAIT;
        cnt_d   = CntW'(WAIT_STATES);
      end else if (!dmem_if.hwrite && port_busy) begin
        state_d = S_WAIT;
        cnt_d   = CntW'(1);
      end else begin
        state_d    = S_DATA;
        fwd_d      = wr_data && !dmem_if.hwrite;
        fwd_data_d = dmem_if.hwdata;
        fwd_strb_d = dmem_if.hwstrb;
      end
    end
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = idx_q;
    if (wr_data) begin
      ram_en = 1'b1;
      ram_we = dmem_if.hwstrb;
    end else if (fast_rd) begin
      ram_en   = 1'b1;
      ram_addr = req_idx;
    end else if (state_q == S_WAIT && cnt_q == CntW'(1) && !write_q) begin
      ram_en = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      fwd_strb_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      fwd_strb_q <= fwd_strb_d;
      hold_q     <= hold_d;
    end
  end

  rv0_dmem_ram #(
    .Depth (Depth),
    .Width (XLEN)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (dmem_if.hwdata),
    .rdata_o (ram_rdata)
  );

  assign dmem_if.hreadyout = ready;
  assign dmem_if.hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign dmem_if.hrdata    = rd_data ? rd_word : hold_q;

endmodule

// File: tb/tb_rv0_dmem.sv
// Directed bench for rv0_dmem: a zero-wait instance and a three-wait instance on one clock.
module tb_rv0_dmem;
  import rv0_dmem_pkg::*;

  localparam int unsigned MEM = 4096;

  logic        clk = 1'b0;
  logic        rst0_n, rst3_n;
  logic        hsel0, hsel3, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hwstrb;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  ahb_if #(.XLEN(32)) bus0 ();
  ahb_if #(.XLEN(32)) bus3 ();

  assign bus0.hsel = hsel0;   assign bus3.hsel = hsel3;
  assign bus0.haddr = haddr;  assign bus3.haddr = haddr;
  assign bus0.htrans = htrans; assign bus3.htrans = htrans;
  assign bus0.hsize = hsize;  assign bus3.hsize = hsize;
  assign bus0.hburst = HBURST_SINGLE; assign bus3.hburst = HBURST_SINGLE;
  assign bus0.hwrite = hwrite; assign bus3.hwrite = hwrite;
  assign bus0.hwdata = hwdata; assign bus3.hwdata = hwdata;
  assign bus0.hwstrb = hwstrb; assign bus3.hwstrb = hwstrb;

  rv0_dmem #(.XLEN(32), .MEM_SIZE(MEM), .WAIT_STATES(0)) u_dmem0 (
    .clk_i   (clk),
    .rst_ni  (rst0_n),
    .dmem_if (bus0)
  );

  rv0_dmem #(.XLEN(32), .MEM_SIZE(MEM), .WAIT_STATES(3)) u_dmem3 (
    .clk_i   (clk),
    .rst_ni  (rst3_n),
    .dmem_if (bus3)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          err;
    bit          chk_rd;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus3.hreadyout : bus0.hreadyout;
  endfunction

  function automatic logic rsp(input bit sel);
    return sel ? bus3.hresp : bus0.hresp;
  endfunction

  function automatic logic [31:0] rdd(input bit sel);
    return sel ? bus3.hrdata : bus0.hrdata;
  endfunction

  // Called #1 after a rising edge with the bus idle; returns #1 after the closing edge.
  task automatic xfer(input bit sel, input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] strb,
                      output int waits, output logic resp_first, output logic resp,
                      output logic [31:0] rdata);
    hsel0 = !sel; hsel3 = sel; htrans = HTRANS_NONSEQ;
    haddr = addr; hsize = size; hwrite = wr;
    @(posedge clk); #1;
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = HTRANS_IDLE;
    hwdata = wdata; hwstrb = strb;
    waits = 0;
    resp_first = rsp(sel);
    while (!rdy(sel) && waits < 16) begin
      @(posedge clk); #1;
      waits++;
    end
    resp  = rsp(sel);
    rdata = rdd(sel);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          w;
    logic        r1, r2;
    logic [31:0] rd;

    rst0_n = 1'b0; rst3_n = 1'b0;
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = HTRANS_IDLE; haddr = '0;
    hsize = HSIZE_WORD; hwrite = 1'b0; hwdata = '0; hwstrb = '0;
    #12;
    check("rst0_ready", bus0.hreadyout, 1); check("rst0_resp", bus0.hresp, 0);
    check("rst0_rdata", bus0.hrdata, 0);
    check("rst3_ready", bus3.hreadyout, 1); check("rst3_resp", bus3.hresp, 0);
    check("rst3_rdata", bus3.hrdata, 0);
    @(posedge clk); #1;
    rst0_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{1'b1, 32'h10,   HSIZE_WORD,  32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h10,   HSIZE_WORD,  32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h00,   HSIZE_WORD,  32'h11111111, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h1000, HSIZE_WORD,  32'h12345678, 4'hF, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h00,   HSIZE_WORD,  32'h0,        4'h0, 1'b0, 1'b1, 32'h11111111});
    vecs.push_back('{1'b0, 32'h13,   HSIZE_HALF,  32'h0,        4'h0, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h14,   HSIZE_WORD,  32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h14,   HSIZE_WORD,  32'h0,        4'h0, 1'b0, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{1'b1, 32'h20,   HSIZE_WORD,  32'h44332211, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h21,   HSIZE_BYTE,  32'h0000AB00, 4'h2, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h20,   HSIZE_WORD,  32'h0,        4'h0, 1'b0, 1'b1, 32'h4433AB11});
    vecs.push_back('{1'b0, 32'h18,   HSIZE_DWORD, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h22,   HSIZE_HALF,  32'h77660000, 4'hC, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h20,   HSIZE_WORD,  32'h0,        4'h0, 1'b0, 1'b1, 32'h7766AB11});
    vecs.push_back('{1'b1, 32'hFFC,  HSIZE_WORD,  32'hA5A5A5A5, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'hFFC,  HSIZE_WORD,  32'h0,        4'h0, 1'b0, 1'b1, 32'hA5A5A5A5});
    vecs.push_back('{1'b1, 32'h02,   HSIZE_WORD,  32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h00,   HSIZE_WORD,  32'h0,        4'h0, 1'b0, 1'b1, 32'h11111111});
    vecs.push_back('{1'b0, 32'h2000, HSIZE_WORD,  32'h0,        4'h0, 1'b1, 1'b1, 32'h0});

    foreach (vecs[i]) begin
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, vecs[i].strb,
           w, r1, r2, rd);
      check($sformatf("v%0d_waits", i), w, vecs[i].err ? 1 : 0);
      check($sformatf("v%0d_resp1", i), r1, vecs[i].err);
      check($sformatf("v%0d_resp2", i), r2, vecs[i].err);
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
    end

    // Byte write to 0x10 followed back-to-back by a read of the same word.
    hsel0 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h10; hsize = HSIZE_BYTE; hwrite = 1'b1;
    @(posedge clk); #1;
    hwdata = 32'h000000AA; hwstrb = 4'b0001; hsize = HSIZE_WORD; hwrite = 1'b0;
    check("fwd_wr_ready", bus0.hreadyout, 1);
    @(posedge clk); #1;
    hsel0 = 1'b0; htrans = HTRANS_IDLE;
    check("fwd_rd_ready", bus0.hreadyout, 1);
    check("fwd_rd_resp", bus0.hresp, 0);
    check("fwd_rd_data", bus0.hrdata, 32'hDEADBEAA);
    @(posedge clk); #1;
    check("fwd_hold", bus0.hrdata, 32'hDEADBEAA);
    xfer(1'b0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 4'h0, w, r1, r2, rd);
    check("fwd_ram_data", rd, 32'hDEADBEAA);

    // Three wait states; address-phase changes during the stall must be ignored.
    xfer(1'b1, 1'b1, 32'h20, HSIZE_WORD, 32'h5A5A0F0F, 4'hF, w, r1, r2, rd);
    check("w3_wr_waits", w, 3);
    xfer(1'b1, 1'b1, 32'h24, HSIZE_WORD, 32'h0BADBAD0, 4'hF, w, r1, r2, rd);
    check("w3_wr2_waits", w, 3);
    hsel3 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20; hsize = HSIZE_WORD; hwrite = 1'b0;
    @(posedge clk); #1;
    haddr = 32'h24; hwrite = 1'b1; hwdata = 32'hFFFFFFFF; hwstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("w3_low%0d", i), bus3.hreadyout, 0);
      @(posedge clk); #1;
    end
    hsel3 = 1'b0; htrans = HTRANS_IDLE;
    check("w3_ready", bus3.hreadyout, 1);
    check("w3_resp", bus3.hresp, 0);
    check("w3_rdata", bus3.hrdata, 32'h5A5A0F0F);
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 32'h24, HSIZE_WORD, 32'h0, 4'h0, w, r1, r2, rd);
    check("w3_ignored_wr", rd, 32'h0BADBAD0);

    // Reset in the wait phase of a write discards it but keeps earlier contents.
    xfer(1'b1, 1'b1, 32'h30, HSIZE_WORD, 32'h30303030, 4'hF, w, r1, r2, rd);
    hsel3 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h30; hsize = HSIZE_WORD; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel3 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF; hwstrb = 4'hF;
    check("rst_wait_low", bus3.hreadyout, 0);
    #2 rst3_n = 1'b0;
    #1;
    check("rst_async_ready", bus3.hreadyout, 1);
    check("rst_async_resp", bus3.hresp, 0);
    @(posedge clk); @(posedge clk); #1;
    rst3_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 32'h30, HSIZE_WORD, 32'h0, 4'h0, w, r1, r2, rd);
    check("rst_rd_waits", w, 3);
    check("rst_rd_data", rd, 32'h30303030);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
